// File: rtl/sr_pkg.sv
// Shared definitions for the SR command path: default timing parameters,
// counter sizing helper and the command encoding seen by the SR stage.
package sr_pkg;

   localparam int SR_DEB_DEFAULT     = 4;
   localparam int SR_HOLDOFF_DEFAULT = 8;

   // Bits needed to hold 0..n; never narrower than one bit so a zero
   // parameter still yields a legal vector.
   function automatic int sr_cnt_w(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

   // Command issued towards the SR flip-flop in a given cycle.
   typedef enum logic [1:0] {
      SR_NONE     = 2'd0,
      SR_SET      = 2'd1,
      SR_CLR      = 2'd2,
      SR_CONFLICT = 2'd3
   } sr_cmd_e;

endpackage

// File: rtl/sr_deb_chan.sv
// One request channel: two-flop synchroniser, debounce counter and
// rising-edge detect on the debounced level.
module sr_deb_chan
   import sr_pkg::*;
#(
   parameter int DEB_CYCLES = SR_DEB_DEFAULT
) (
   input  logic clk,
   input  logic rstn,
   input  logic req,
   output logic lvl,
   output logic rise
);

   localparam int            CW       = sr_cnt_w(DEB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          lvl_q;
   logic          lvl_d;
   logic          lvl_prev_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Bring the raw asynchronous request into the clk domain.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= req;
         sync2_q <= sync1_q;
      end
   end

   // Accept a new level only after it has differed for DEB_CYCLES cycles in a
   // row; any return to the current level restarts the count.
   always_comb begin
      lvl_d = lvl_q;
      cnt_d = cnt_q;
      if (sync2_q == lvl_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         lvl_d = sync2_q;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Debounced level, its one-cycle delayed copy and the count.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lvl_q      <= 1'b0;
         lvl_prev_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         lvl_q      <= lvl_d;
         lvl_prev_q <= lvl_q;
         cnt_q      <= cnt_d;
      end
   end

   // Only 0->1 transitions of the debounced level count as requests.
   assign rise = lvl_q & ~lvl_prev_q;
   assign lvl  = lvl_q;

endmodule

// File: rtl/sr_cmd_gen.sv
// Command generator for the SR flip-flop: debounces the set and clear request
// lines and arbitrates their rising edges into clean one-cycle s/r strobes,
// with conflict detection, enable gating and a post-strobe hold-off window.
module sr_cmd_gen
   import sr_pkg::*;
#(
   parameter int DEB_CYCLES = SR_DEB_DEFAULT,
   parameter int HOLDOFF    = SR_HOLDOFF_DEFAULT
) (
   input  logic clk,
   input  logic rstn,
   input  logic en,
   input  logic set_req,
   input  logic clr_req,
   output logic s,
   output logic r,
   output logic conflict,
   output logic dropped,
   output logic set_lvl,
   output logic clr_lvl
);

   localparam int            HW        = sr_cnt_w(HOLDOFF);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF);

   logic          rise_set;
   logic          rise_clr;
   logic          set_lvl_w;
   logic          clr_lvl_w;

   sr_cmd_e       cmd_d;
   logic          drop_d;
   logic [HW-1:0] hold_q;
   logic [HW-1:0] hold_d;

   logic          s_q;
   logic          r_q;
   logic          conflict_q;
   logic          dropped_q;

   sr_deb_chan #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_set_chan (
      .clk  (clk),
      .rstn (rstn),
      .req  (set_req),
      .lvl  (set_lvl_w),
      .rise (rise_set)
   );

   sr_deb_chan #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_clr_chan (
      .clk  (clk),
      .rstn (rstn),
      .req  (clr_req),
      .lvl  (clr_lvl_w),
      .rise (rise_clr)
   );

   // Decide what each debounced edge turns into. The hold-off only reloads
   // from zero, so a reload and a decrement can never land in the same cycle.
   always_comb begin
      cmd_d  = SR_NONE;
      drop_d = 1'b0;
      hold_d = (hold_q != '0) ? hold_q - HW'(1) : hold_q;
      if (rise_set || rise_clr) begin
         if (!en || (hold_q != '0)) begin
            drop_d = 1'b1;
         end else if (rise_set && rise_clr) begin
            cmd_d = SR_CONFLICT;
         end else begin
            cmd_d  = rise_set ? SR_SET : SR_CLR;
            hold_d = HOLD_LOAD;
         end
      end
   end

   // Register every output flag and the hold-off counter.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s_q        <= 1'b0;
         r_q        <= 1'b0;
         conflict_q <= 1'b0;
         dropped_q  <= 1'b0;
         hold_q     <= '0;
      end else begin
         s_q        <= (cmd_d == SR_SET);
         r_q        <= (cmd_d == SR_CLR);
         conflict_q <= (cmd_d == SR_CONFLICT);
         dropped_q  <= drop_d;
         hold_q     <= hold_d;
      end
   end

   assign s        = s_q;
   assign r        = r_q;
   assign conflict = conflict_q;
   assign dropped  = dropped_q;
   assign set_lvl  = set_lvl_w;
   assign clr_lvl  = clr_lvl_w;

   // The SR stage must never see set and reset together.
   a_s_r_exclusive : assert property (@(posedge clk) disable iff (!rstn) !(s_q && r_q));

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Directed bench for sr_cmd_gen with DEB_CYCLES=4, HOLDOFF=8.
// Each scenario is a per-edge table of inputs and expected outputs; entry i
// is the input sampled at relative edge i and the outputs seen just after it.
module tb_sr_cmd_gen;

   localparam int N = 64;
   localparam int T_SV  = 0;
   localparam int T_CV  = 1;
   localparam int T_EN0 = 2;
   localparam int T_ESL = 3;
   localparam int T_ECL = 4;

   logic clk = 1'b0;
   logic rstn = 1'b1;
   logic en = 1'b1;
   logic set_req = 1'b0;
   logic clr_req = 1'b0;
   logic s, r, conflict, dropped, set_lvl, clr_lvl;

   int total = 0;
   int bad = 0;

   logic sv  [N];
   logic cv  [N];
   logic ev  [N];
   logic es  [N];
   logic er  [N];
   logic ec  [N];
   logic ed  [N];
   logic esl [N];
   logic ecl [N];

   sr_cmd_gen #(
      .DEB_CYCLES (4),
      .HOLDOFF    (8)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .en       (en),
      .set_req  (set_req),
      .clr_req  (clr_req),
      .s        (s),
      .r        (r),
      .conflict (conflict),
      .dropped  (dropped),
      .set_lvl  (set_lvl),
      .clr_lvl  (clr_lvl)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] outs();
      return {26'd0, s, r, conflict, dropped, set_lvl, clr_lvl};
   endfunction

   task automatic clr_vec();
      for (int i = 0; i < N; i++) begin
         sv[i] = 1'b0; cv[i] = 1'b0; ev[i] = 1'b1;
         es[i] = 1'b0; er[i] = 1'b0; ec[i] = 1'b0; ed[i] = 1'b0;
         esl[i] = 1'b0; ecl[i] = 1'b0;
      end
   endtask

   task automatic rng(input int sel, input int a, input int b);
      for (int i = a; i <= b; i++) begin
         case (sel)
            T_SV:    sv[i]  = 1'b1;
            T_CV:    cv[i]  = 1'b1;
            T_EN0:   ev[i]  = 1'b0;
            T_ESL:   esl[i] = 1'b1;
            default: ecl[i] = 1'b1;
         endcase
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input string name, input int n);
      for (int i = 0; i < n; i++) begin
         set_req = sv[i];
         clr_req = cv[i];
         en      = ev[i];
         step();
         chk($sformatf("%s@%0d {s,r,cf,dr,sl,cl}", name, i), outs(),
             {26'd0, es[i], er[i], ec[i], ed[i], esl[i], ecl[i]});
      end
      set_req = 1'b0;
      clr_req = 1'b0;
      en      = 1'b1;
   endtask

   initial begin
      // Asynchronous reset with no clock edge yet.
      #1 rstn = 1'b0;
      #1 chk("reset_async", outs(), 32'd0);
      step();
      step();
      chk("reset_held", outs(), 32'd0);
      rstn = 1'b1;
      for (int i = 0; i < 4; i++) step();
      chk("idle", outs(), 32'd0);

      // Clean press held 20 cycles.
      clr_vec();
      rng(T_SV, 0, 19);
      rng(T_ESL, 5, 24);
      es[6] = 1'b1;
      run("clean", 32);

      // Bouncing clear request: 1,0,1,1,0 then steady high.
      clr_vec();
      cv[0] = 1'b1; cv[2] = 1'b1; cv[3] = 1'b1;
      rng(T_CV, 5, 19);
      rng(T_ECL, 10, 24);
      er[11] = 1'b1;
      run("bounce", 32);

      // Simultaneous rises, then the fastest possible set re-press which
      // would fall inside a hold-off window had the conflict loaded one.
      clr_vec();
      rng(T_SV, 0, 3);
      rng(T_SV, 8, 19);
      rng(T_CV, 0, 3);
      rng(T_ESL, 5, 8);
      rng(T_ESL, 13, 24);
      rng(T_ECL, 5, 8);
      ec[6] = 1'b1;
      es[14] = 1'b1;
      run("simul", 34);

      // Hold-off: clear rise 3 cycles after s is dropped, 11 cycles after issues r.
      clr_vec();
      rng(T_SV, 0, 19);
      rng(T_CV, 3, 6);
      rng(T_CV, 11, 19);
      rng(T_ESL, 5, 24);
      rng(T_ECL, 8, 11);
      rng(T_ECL, 16, 24);
      es[6] = 1'b1;
      ed[9] = 1'b1;
      er[17] = 1'b1;
      run("holdoff", 34);

      // Enable low during a set press.
      clr_vec();
      rng(T_SV, 0, 19);
      rng(T_EN0, 0, 12);
      rng(T_ESL, 5, 24);
      ed[6] = 1'b1;
      run("enable", 32);

      // Reset just before a pending strobe, request still held afterwards.
      set_req = 1'b1;
      for (int i = 0; i < 6; i++) step();
      chk("rst_pre_lvl", outs(), 32'h2);
      rstn = 1'b0;
      #1 chk("rst_mid_async", outs(), 32'd0);
      step();
      chk("rst_mid_held", outs(), 32'd0);
      step();
      rstn = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         chk($sformatf("rst_after@%0d", i), outs(),
             {26'd0, (i == 6), 3'b000, (i >= 5), 1'b0});
      end
      set_req = 1'b0;
      for (int i = 0; i < 10; i++) step();
      chk("final_idle", outs(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
